cache_fill_ctrl: RTL

CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

---
 rtl/cache_fill_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/cache_fill_ctrl.sv
// rtl/cache_fill_ctrl.sv - I/D cache block fill controller with D-side priority
module cache_fill_ctrl #(
    parameter int BLOCK_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_miss,
    input  logic [15:0] icache_addr,
    input  logic        dcache_miss,
    input  logic [15:0] dcache_addr,
    output logic        mem_en,
    output logic [15:0] mem_addr,
    input  logic        mem_data_valid,
    input  logic [15:0] mem_data,
    output logic [15:0] fill_addr,
    output logic [15:0] fill_data,
    output logic        icache_write_data,
    output logic        icache_write_tag,
    output logic        dcache_write_data,
    output logic        dcache_write_tag,
    output logic        fill_done_i,
    output logic        fill_done_d,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_e;

    localparam logic [3:0] LAST = 4'(BLOCK_WORDS - 1);

    state_e      state_q;
    logic [15:0] base_q;
    logic        sel_d_q;
    logic [3:0]  issue_cnt_q;
    logic [3:0]  ret_cnt_q;

    logic wr;
    logic last_wr;

    // Every output is gated by rst so nothing leaks while reset is held.
    assign wr      = rst && mem_data_valid && (state_q == ISSUE || state_q == DRAIN);
    assign last_wr = wr && (ret_cnt_q == LAST);

    assign mem_en            = rst && (state_q == ISSUE);
    assign mem_addr          = mem_en ? base_q + {11'b0, issue_cnt_q, 1'b0} : 16'h0;
    assign fill_addr         = wr ? base_q + {11'b0, ret_cnt_q, 1'b0} : 16'h0;
    assign fill_data         = wr ? mem_data : 16'h0;
    assign icache_write_data = wr && !sel_d_q;
    assign dcache_write_data = wr && sel_d_q;
    assign icache_write_tag  = last_wr && !sel_d_q;
    assign dcache_write_tag  = last_wr && sel_d_q;
    assign fill_done_i       = rst && (state_q == FINISH) && !sel_d_q;
    assign fill_done_d       = rst && (state_q == FINISH) && sel_d_q;
    assign busy              = rst && (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            base_q      <= 16'h0;
            sel_d_q     <= 1'b0;
            issue_cnt_q <= 4'd0;
            ret_cnt_q   <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dcache_miss || icache_miss) begin
                        sel_d_q     <= dcache_miss;
                        base_q      <= (dcache_miss ? dcache_addr : icache_addr) & 16'hFFF0;
                        issue_cnt_q <= 4'd0;
                        ret_cnt_q   <= 4'd0;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE, DRAIN: begin
                    if (state_q == ISSUE) begin
                        if (issue_cnt_q == LAST) begin
                            state_q <= DRAIN;
                        end else begin
                            issue_cnt_q <= issue_cnt_q + 4'd1;
                        end
                    end
                    // Return counting lives after issue so the final write wins the transition.
                    if (wr) begin
                        if (last_wr) begin
                            state_q <= FINISH;
                        end else begin
                            ret_cnt_q <= ret_cnt_q + 4'd1;
                        end
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
